// File: rtl/reservation_station.sv
// Integer-pipeline reservation station: resolves operands at dispatch, snoops the CDBs for
// outstanding tags and issues the oldest fully-ready entry to the ALU.
module reservation_station #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned OP_W    = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NUM_CDB = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OP_W-1:0]              in_op,
  input  logic [TAG_W-1:0]             in_dest_tag,
  input  logic [XLEN:0]                arf_data1,
  input  logic [XLEN:0]                arf_data2,
  input  logic [TAG_W-1:0]             arf_tag1,
  input  logic [TAG_W-1:0]             arf_tag2,
  input  logic [XLEN:0]                rob_data1,
  input  logic [XLEN:0]                rob_data2,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]     cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]      cdb_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OP_W-1:0]              out_op,
  output logic [XLEN-1:0]              out_src1,
  output logic [XLEN-1:0]              out_src2,
  output logic [TAG_W-1:0]             out_dest_tag,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [OP_W-1:0]  op_q   [DEPTH];
  logic [OP_W-1:0]  op_d   [DEPTH];
  logic [TAG_W-1:0] dest_q [DEPTH];
  logic [TAG_W-1:0] dest_d [DEPTH];
  logic [XLEN:0]    src1_q [DEPTH];
  logic [XLEN:0]    src1_d [DEPTH];
  logic [XLEN:0]    src2_q [DEPTH];
  logic [XLEN:0]    src2_d [DEPTH];
  // older_q[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  logic [DEPTH-1:0] free, alloc_oh, rdy_vec, sel;
  logic             disp_fire, issue_fire;
  logic [XLEN:0]    res1, res2;

  // Returns the lowest-index matching CDB value, or dflt when no bus matches.
  function automatic logic [XLEN:0] snoop(input logic [TAG_W-1:0] tag,
                                          input logic [XLEN:0]    dflt);
    logic [XLEN:0] r;
    logic          hit;
    r   = dflt;
    hit = 1'b0;
    for (int i = 0; i < NUM_CDB; i++) begin
      if (!hit && cdb_valid[i] && (cdb_tag[i*TAG_W +: TAG_W] == tag)) begin
        r   = {1'b1, cdb_data[i*XLEN +: XLEN]};
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [XLEN:0] resolve(input logic [XLEN:0]  arf,
                                            input logic [TAG_W-1:0] tag,
                                            input logic [XLEN:0]  rob);
    logic [XLEN:0] w;
    if (!arf[XLEN]) return {1'b1, arf[XLEN-1:0]};
    if (rob[XLEN]) begin
      w = {1'b1, rob[XLEN-1:0]};
    end else begin
      w = '0;
      w[TAG_W-1:0] = tag;
    end
    return snoop(tag, w);
  endfunction

  function automatic logic [XLEN:0] wake(input logic [XLEN:0] s);
    if (s[XLEN]) return s;
    return snoop(s[TAG_W-1:0], s);
  endfunction

  assign free       = ~valid_q;
  assign alloc_oh   = free & (~free + DEPTH'(1));
  assign in_ready   = |free;
  assign disp_fire  = in_valid && in_ready && !flush;
  assign issue_fire = out_valid && out_ready;
  assign res1       = resolve(arf_data1, arf_tag1, rob_data1);
  assign res2       = resolve(arf_data2, arf_tag2, rob_data2);

  // Oldest-ready select: a candidate wins when no other candidate is older.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy_vec[i] = valid_q[i] && src1_q[i][XLEN] && src2_q[i][XLEN];
    end
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = rdy_vec[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && rdy_vec[j] && older_q[j][i]) sel[i] = 1'b0;
      end
    end
  end

  always_comb begin
    out_valid    = |rdy_vec;
    out_op       = '0;
    out_src1     = '0;
    out_src2     = '0;
    out_dest_tag = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        out_op       = out_op | op_q[i];
        out_src1     = out_src1 | src1_q[i][XLEN-1:0];
        out_src2     = out_src2 | src2_q[i][XLEN-1:0];
        out_dest_tag = out_dest_tag | dest_q[i];
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + CNT_W'(valid_q[i]);
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      op_d[i]    = op_q[i];
      dest_d[i]  = dest_q[i];
      src1_d[i]  = wake(src1_q[i]);
      src2_d[i]  = wake(src2_q[i]);
      older_d[i] = older_q[i];
    end
    if (issue_fire) valid_d = valid_d & ~sel;
    if (disp_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_oh[i]) begin
          valid_d[i] = 1'b1;
          op_d[i]    = in_op;
          dest_d[i]  = in_dest_tag;
          src1_d[i]  = res1;
          src2_d[i]  = res2;
          for (int j = 0; j < DEPTH; j++) begin
            older_d[j][i] = (j != i);
          end
          older_d[i] = '0;
        end
      end
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]    <= '0;
        dest_q[i]  <= '0;
        src1_q[i]  <= '0;
        src2_q[i]  <= '0;
        older_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]    <= op_d[i];
        dest_q[i]  <= dest_d[i];
        src1_q[i]  <= src1_d[i];
        src2_q[i]  <= src2_d[i];
        older_q[i] <= older_d[i];
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: dispatch resolve, wakeup, age order, backpressure,
// flush and reset.
module tb_reservation_station;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_op, out_op;
  logic [5:0]  in_dest_tag, arf_tag1, arf_tag2, out_dest_tag;
  logic [32:0] arf_data1, arf_data2, rob_data1, rob_data2;
  logic [1:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic [63:0] cdb_data;
  logic [31:0] out_src1, out_src2;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  reservation_station dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_dest_tag(in_dest_tag), .arf_data1(arf_data1), .arf_data2(arf_data2),
    .arf_tag1(arf_tag1), .arf_tag2(arf_tag2), .rob_data1(rob_data1), .rob_data2(rob_data2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_op(out_op), .out_src1(out_src1), .out_src2(out_src2),
    .out_dest_tag(out_dest_tag), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; in_valid = 0; out_ready = 0; in_op = 0; in_dest_tag = 0;
    arf_data1 = 0; arf_data2 = 0; arf_tag1 = 0; arf_tag2 = 0;
    rob_data1 = 0; rob_data2 = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    tick(); tick();
    rst = 0;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0 || out_src1 !== 0 || out_dest_tag !== 0) begin
      errors++; $display("FAIL reset_out: got v=%0b s1=%0h d=%0d want 0 0 0", out_valid, out_src1, out_dest_tag); end
  endtask

  task automatic test_arf_dispatch();
    in_valid = 1; in_op = 8'h01; in_dest_tag = 6'd5;
    arf_data1 = {1'b0, 32'h11}; arf_data2 = {1'b0, 32'h22};
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arf_valid: got %0b want 1", out_valid); end
    checks++; if (out_src1 !== 32'h11 || out_src2 !== 32'h22) begin
      errors++; $display("FAIL arf_srcs: got %0h %0h want 11 22", out_src1, out_src2); end
    checks++; if (out_dest_tag !== 6'd5 || out_op !== 8'h01) begin
      errors++; $display("FAIL arf_dest_op: got %0d %0h want 5 1", out_dest_tag, out_op); end
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL arf_occ: got %0d want 1", occupancy); end
    out_ready = 1; tick(); out_ready = 0;
    checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0 || out_src1 !== 0) begin
      errors++; $display("FAIL arf_issue: got occ=%0d v=%0b s1=%0h want 0 0 0", occupancy, out_valid, out_src1); end
  endtask

  task automatic test_bypass();
    // bus1 bypass beats a ready ROB value
    in_valid = 1; in_dest_tag = 6'd6;
    arf_data1 = {1'b1, 32'h0}; arf_tag1 = 6'd3; rob_data1 = {1'b1, 32'h77};
    arf_data2 = {1'b0, 32'h05};
    cdb_valid = 2'b10; cdb_tag = {6'd3, 6'd9}; cdb_data = {32'hAB, 32'hCD};
    tick();
    in_valid = 0; cdb_valid = 0; rob_data1 = 0;
    checks++; if (out_valid !== 1'b1 || out_src1 !== 32'hAB) begin
      errors++; $display("FAIL bypass_bus1: got v=%0b s1=%0h want 1 ab", out_valid, out_src1); end
    // lowest bus wins; dispatch and issue in the same cycle
    in_valid = 1; out_ready = 1; in_dest_tag = 6'd12; arf_tag1 = 6'd4;
    cdb_valid = 2'b11; cdb_tag = {6'd4, 6'd4}; cdb_data = {32'hAB, 32'hCD};
    tick();
    in_valid = 0; out_ready = 0; cdb_valid = 0;
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL same_cycle_occ: got %0d want 1", occupancy); end
    checks++; if (out_src1 !== 32'hCD || out_dest_tag !== 6'd12) begin
      errors++; $display("FAIL bypass_bus0: got s1=%0h d=%0d want cd 12", out_src1, out_dest_tag); end
    // no CDB hit: ROB value used
    in_valid = 1; out_ready = 1; in_dest_tag = 6'd13; arf_tag1 = 6'd8; rob_data1 = {1'b1, 32'h44};
    tick();
    in_valid = 0; rob_data1 = 0;
    checks++; if (out_valid !== 1'b1 || out_src1 !== 32'h44 || out_dest_tag !== 6'd13) begin
      errors++; $display("FAIL rob_path: got v=%0b s1=%0h d=%0d want 1 44 13", out_valid, out_src1, out_dest_tag); end
    tick(); out_ready = 0;
  endtask

  task automatic test_wakeup();
    in_valid = 1; in_dest_tag = 6'd7;
    arf_data1 = {1'b0, 32'h1}; arf_data2 = {1'b1, 32'h0}; arf_tag2 = 6'd7; rob_data2 = 0;
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 3'd1) begin
      errors++; $display("FAIL wake_wait: got v=%0b occ=%0d want 0 1", out_valid, occupancy); end
    tick();
    cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd7}; cdb_data = {32'h0, 32'h99};
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wake_early: got %0b want 0", out_valid); end
    tick();
    cdb_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_src2 !== 32'h99 || out_dest_tag !== 6'd7) begin
      errors++; $display("FAIL wake_issue: got v=%0b s2=%0h d=%0d want 1 99 7", out_valid, out_src2, out_dest_tag); end
    out_ready = 1; tick(); out_ready = 0;
  endtask

  task automatic test_age_order();
    in_valid = 1; in_dest_tag = 6'd10;
    arf_data1 = {1'b1, 32'h0}; arf_tag1 = 6'd2; rob_data1 = 0; arf_data2 = {1'b0, 32'h2};
    tick();
    in_dest_tag = 6'd11; arf_data1 = {1'b0, 32'h3}; arf_data2 = {1'b0, 32'h4};
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_dest_tag !== 6'd11) begin
      errors++; $display("FAIL age_young_first: got v=%0b d=%0d want 1 11", out_valid, out_dest_tag); end
    cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd2}; cdb_data = {32'h0, 32'h55};
    tick();
    cdb_valid = 0;
    checks++; if (out_dest_tag !== 6'd10 || out_src1 !== 32'h55) begin
      errors++; $display("FAIL age_older_wins: got d=%0d s1=%0h want 10 55", out_dest_tag, out_src1); end
    out_ready = 1; tick();
    checks++; if (out_dest_tag !== 6'd11) begin errors++; $display("FAIL age_second: got %0d want 11", out_dest_tag); end
    tick(); out_ready = 0;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL age_drain: got %0d want 0", occupancy); end
  endtask

  task automatic test_full();
    arf_data1 = {1'b1, 32'h0}; arf_tag1 = 6'd20; rob_data1 = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_dest_tag = 6'(20 + k); arf_data2 = {1'b0, 32'(k)};
      tick();
    end
    checks++; if (occupancy !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL full_state: got occ=%0d rdy=%0b v=%0b want 4 0 0", occupancy, in_ready, out_valid); end
    in_dest_tag = 6'd30;
    tick();
    in_valid = 0;
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_ignore: got %0d want 4", occupancy); end
    cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd20}; cdb_data = {32'h0, 32'h33};
    tick();
    cdb_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_dest_tag !== 6'd20 || out_src1 !== 32'h33) begin
      errors++; $display("FAIL full_oldest: got v=%0b d=%0d s1=%0h want 1 20 33", out_valid, out_dest_tag, out_src1); end
    out_ready = 1; tick(); out_ready = 0;
    checks++; if (in_ready !== 1'b1 || occupancy !== 3'd3 || out_dest_tag !== 6'd21) begin
      errors++; $display("FAIL full_release: got rdy=%0b occ=%0d d=%0d want 1 3 21", in_ready, occupancy, out_dest_tag); end
    in_valid = 1; out_ready = 1; in_dest_tag = 6'd24; arf_data1 = {1'b0, 32'h0};
    tick();
    in_valid = 0; out_ready = 0;
    checks++; if (occupancy !== 3'd3 || out_dest_tag !== 6'd22) begin
      errors++; $display("FAIL full_reuse: got occ=%0d d=%0d want 3 22", occupancy, out_dest_tag); end
    flush = 1; tick(); flush = 0;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL full_flush: got %0d want 0", occupancy); end
  endtask

  task automatic test_flush_reset();
    arf_data1 = {1'b0, 32'h7}; arf_data2 = {1'b0, 32'h8};
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_dest_tag = 6'(40 + k);
      tick();
    end
    checks++; if (occupancy !== 3'd3 || out_dest_tag !== 6'd40) begin
      errors++; $display("FAIL flush_fill: got occ=%0d d=%0d want 3 40", occupancy, out_dest_tag); end
    flush = 1; in_dest_tag = 6'd43;
    tick();
    flush = 0; in_valid = 0;
    checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_clear: got occ=%0d v=%0b rdy=%0b want 0 0 1", occupancy, out_valid, in_ready); end
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; in_dest_tag = 6'(50 + k);
      tick();
    end
    rst = 1; out_ready = 1; in_dest_tag = 6'd52;
    tick();
    rst = 0; clear_inputs();
    checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0 || out_dest_tag !== 0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid: got occ=%0d v=%0b d=%0d rdy=%0b want 0 0 0 1",
                         occupancy, out_valid, out_dest_tag, in_ready); end
  endtask

  initial begin
    test_reset();
    test_arf_dispatch();
    test_bypass();
    test_wakeup();
    test_age_order();
    test_full();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
